systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Operand sequencer and transmitter that drives the a_in, b_in and we inputs of the 4x4 systolic array.
- Host writes matrices A (NxN activations) and B (NxN weights) into local buffers. On start, the block emits diagonally skewed row and column streams so that A[r][k] and B[k][c] meet in PE(r,c) on the same cycle.
- Sits between the control/host write path and the array.

Parameters:
- DATA_WIDTH, 8, bit-width of each A/B element and of each output lane.
- N, 4, array dimension (rows = cols = inner dimension K).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_sel  input  1  0 = write A buffer, 1 = write B buffer.
- wr_addr  input  4  element index, row*N + col (row-major).
- wr_data  input  DATA_WIDTH  element value.
- start  input  1  single-cycle request to begin a feed sequence.
- a_out  output  DATA_WIDTH*N  row lanes to array a_in; row r in bits [DATA_WIDTH*(r+1)-1 : DATA_WIDTH*r].
- b_out  output  DATA_WIDTH*N  column lanes to array b_in; column c packed the same way.
- we_out  output  1  array enable, to array we.
- busy  output  1  high while a sequence is running.
- done  output  1  one-cycle pulse after the last enabled cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; cycle counter t=0.
  - a_out=0, b_out=0, we_out=0, busy=0, done=0.
  - All A/B buffer entries cleared to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN with t=0.
  - RUN: t increments each cycle. When t = 3N-3 (9 for N=4), go to DONE on the next edge.
  - DONE: lasts one cycle, then IDLE unconditionally.
- Outputs are registered. The cycle after start is sampled is the first RUN cycle (t=0). On that cycle we_out=1 and the lanes carry their t=0 values.
- Lane values during RUN at step t:
  - Row lane r: a_out lane r = A[r][t-r] if 0 <= t-r <= N-1, else 0.
  - Column lane c: b_out lane c = B[t-c][c] if 0 <= t-c <= N-1, else 0.
- RUN timing:
  - RUN lasts 3N-2 cycles (10 for N=4), with we_out=1 on every one of them.
  - The zero-padding cycles after t=2N-2 drain the pipeline so that PE(N-1,N-1) receives its last operands at t=3N-3.
- DONE cycle: done=1, we_out=0, lanes=0, busy=0. busy=1 exactly during RUN.
- In IDLE and DONE: we_out=0 and lanes=0.
- Writes:
  - Accepted in IDLE and DONE. Ignored (buffer unchanged) during RUN.
  - wr_addr values >= N*N are ignored.
  - Buffer contents persist across sequences, so re-issuing start replays the same matrices.
- Simultaneous wr_en and start in IDLE: the write is committed, and the sequence uses the updated value.
- start while in RUN: ignored, with no restart and no queueing. start in the DONE cycle: ignored.
- Reset asserted mid-RUN: outputs drop to 0 immediately (asynchronously), buffers are cleared, and there is no done pulse.
- No arithmetic is performed in this block. Values are passed through unmodified, with no sign handling.

Test Plan:
- Reset check: rst_n low, then release -> all outputs 0, busy=0. Then start with empty buffers -> 10 cycles of we_out=1 with all lanes 0, then done=1 for 1 cycle.
- Skew check:
  - Stimulus: load A[r][k]=16*r+k+1 and B[k][c]=16*k+c+0x81, then pulse start.
  - At t=0: a lane0=0x01, others 0; b lane0=0x81.
  - At t=3: a lanes = {0x31,0x22,0x13,0x04} (lane3..lane0).
  - At t=6: a lane3=0x34 and b lane3=0xB4; all lanes 0 at t=7..9.
- End-to-end with the array:
  - A=identity, B[k][c]=k*4+c, then start.
  - After done, the array data_out equals B row-major (0x00..0x0F).
- Write lockout: wr_en to A[0][0]=0xFF during RUN t=2 -> that sequence and a replayed second sequence both show the original A[0][0].
- Start while busy: start pulse at t=4 -> sequence still ends after 10 we cycles, with exactly one done pulse.
- Reset mid-run: rst_n low at t=5 -> a_out/b_out/we_out/busy go to 0 without waiting for a clock edge, and no done pulse. After release, start yields all-zero lanes, showing the buffers were cleared.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand sequencer for an NxN systolic array: buffers A and B, then streams
// them diagonally skewed so A[r][k] and B[k][c] meet in PE(r,c) on the same cycle.
module systolic_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [3:0]                 wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       start,
  output logic [DATA_WIDTH*N-1:0]    a_out,
  output logic [DATA_WIDTH*N-1:0]    b_out,
  output logic                       we_out,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CELLS   = N * N;
  localparam int unsigned ADDR_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned CNT_W   = $clog2(3 * N);
  localparam int unsigned LANES_W = DATA_WIDTH * N;
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(3 * N - 3);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      t;
  logic [CNT_W-1:0]      t_nxt;

  logic [DATA_WIDTH-1:0] a_buf [CELLS];
  logic [DATA_WIDTH-1:0] b_buf [CELLS];
  logic [DATA_WIDTH-1:0] a_eff [CELLS];
  logic [DATA_WIDTH-1:0] b_eff [CELLS];

  logic                  wr_ok_c;
  logic [LANES_W-1:0]    a_nxt;
  logic [LANES_W-1:0]    b_nxt;
  logic                  we_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;

  assign wr_ok_c = wr_en && (state != S_RUN) && (32'(wr_addr) < CELLS);

  // Write-forwarded view so a write coinciding with start feeds the new value on t=0
  always_comb begin
    a_eff = a_buf;
    b_eff = b_buf;
    if (wr_ok_c) begin
      if (wr_sel) b_eff[wr_addr] = wr_data;
      else        a_eff[wr_addr] = wr_data;
    end
  end

  // Operand buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CELLS); i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (wr_ok_c) begin
      if (wr_sel) b_buf[wr_addr] <= wr_data;
      else        a_buf[wr_addr] <= wr_data;
    end
  end

  // Next state and next registered outputs (lanes are computed for the upcoming step)
  always_comb begin
    int k;
    state_nxt = state;
    t_nxt     = t;
    a_nxt     = '0;
    b_nxt     = '0;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    k         = 0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          t_nxt     = '0;
        end
      end
      S_RUN: begin
        if (t == LAST_T) begin
          state_nxt = S_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
      end
    endcase

    if (state_nxt == S_RUN) begin
      we_nxt   = 1'b1;
      busy_nxt = 1'b1;
      for (int r = 0; r < int'(N); r++) begin
        k = int'(t_nxt) - r;
        if (k >= 0 && k < int'(N))
          a_nxt[r*DATA_WIDTH +: DATA_WIDTH] = a_eff[ADDR_W'(r * int'(N) + k)];
      end
      for (int c = 0; c < int'(N); c++) begin
        k = int'(t_nxt) - c;
        if (k >= 0 && k < int'(N))
          b_nxt[c*DATA_WIDTH +: DATA_WIDTH] = b_eff[ADDR_W'(k * int'(N) + c)];
      end
    end

    if (state_nxt == S_DONE) done_nxt = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      t      <= '0;
      a_out  <= '0;
      b_out  <= '0;
      we_out <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      t      <= t_nxt;
      a_out  <= a_nxt;
      b_out  <= b_nxt;
      we_out <= we_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus queues expected output words per
// cycle; a monitor pops and compares them one time unit after each rising edge.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic          wr_sel;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [31:0]   a_out;
  logic [31:0]   b_out;
  logic          we_out;
  logic          busy;
  logic          done;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .a_out(a_out), .b_out(b_out),
    .we_out(we_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic        bsy;
    logic        dn;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ma [16];
  logic [7:0]  mb [16];

  task automatic compare(input exp_t e);
    tests++;
    if (a_out !== e.a || b_out !== e.b || we_out !== e.we || busy !== e.bsy || done !== e.dn) begin
      fails++;
      $display("FAIL %s cyc=%0d got a=%h b=%h we=%b busy=%b done=%b expected a=%h b=%h we=%b busy=%b done=%b",
               e.tag, cyc, a_out, b_out, we_out, busy, done, e.a, e.b, e.we, e.bsy, e.dn);
    end
  endtask

  // Monitor: compare every queued expectation that targets this cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          compare(sb[i]);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  function automatic logic [31:0] lane_a(input int t);
    logic [31:0] v = '0;
    for (int r = 0; r < N; r++)
      if (t - r >= 0 && t - r < N) v[r*8 +: 8] = ma[r*N + t - r];
    return v;
  endfunction

  function automatic logic [31:0] lane_b(input int t);
    logic [31:0] v = '0;
    for (int c = 0; c < N; c++)
      if (t - c >= 0 && t - c < N) v[c*8 +: 8] = mb[(t - c)*N + c];
    return v;
  endfunction

  task automatic push(input int c, input logic [31:0] a, input logic [31:0] b,
                      input logic we, input logic bsy, input logic dn, input string tag);
    exp_t e;
    e.cyc = c; e.a = a; e.b = b; e.we = we; e.bsy = bsy; e.dn = dn; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wr(input logic sel, input int addr, input logic [7:0] d);
    @(negedge clk);
    start = 0; wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
    if (sel) mb[addr] = d; else ma[addr] = d;
  endtask

  // One feed sequence. wr_t: -1 = write alongside start, 0..11 = step of the write,
  // other = no write. A write at steps 0..9 falls in RUN and must not reach the model.
  task automatic run_seq(input string tag, input int wr_t, input int waddr,
                         input logic [7:0] wdata, input int st_t);
    int base;
    @(negedge clk);
    wr_en = 0; start = 1;
    if (wr_t == -1) begin
      wr_en = 1; wr_sel = 0; wr_addr = 4'(waddr); wr_data = wdata;
      ma[waddr] = wdata;
    end
    base = cyc + 1;
    for (int t = 0; t < 3*N-2; t++) push(base + t, lane_a(t), lane_b(t), 1'b1, 1'b1, 1'b0, tag);
    push(base + 3*N-2, '0, '0, 1'b0, 1'b0, 1'b1, {tag, "_done"});
    push(base + 3*N-1, '0, '0, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
    push(base + 3*N,   '0, '0, 1'b0, 1'b0, 1'b0, {tag, "_idle2"});
    for (int i = 0; i < 3*N; i++) begin
      @(negedge clk);
      wr_en = 0; start = 0;
      if (i == wr_t) begin
        wr_en = 1; wr_sel = 0; wr_addr = 4'(waddr); wr_data = wdata;
        if (i >= 3*N-2) ma[waddr] = wdata;
      end
      if (i == st_t) start = 1;
    end
    @(negedge clk);
    wr_en = 0; start = 0;
    @(negedge clk);
  endtask

  task automatic chk_zero_now(input string tag);
    exp_t e;
    e.cyc = cyc; e.a = '0; e.b = '0; e.we = 0; e.bsy = 0; e.dn = 0; e.tag = tag;
    compare(e);
  endtask

  initial begin
    int base;
    rst_n = 0; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; start = 0;
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    #1;
    chk_zero_now("reset_outputs");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    push(cyc + 1, '0, '0, 1'b0, 1'b0, 1'b0, "post_reset_idle");
    @(negedge clk);

    run_seq("empty_bufs", 99, 0, 8'h00, 99);

    // Skew pattern with hand-computed spot checks
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) begin
        wr(1'b0, r*N + k, 8'(16*r + k + 1));
        wr(1'b1, r*N + k, 8'(16*r + k + 8'h81));
      end
    base = cyc + 2;
    push(base + 0, 32'h00000001, 32'h00000081, 1'b1, 1'b1, 1'b0, "skew_t0");
    push(base + 3, 32'h31221304, 32'h8493A2B1, 1'b1, 1'b1, 1'b0, "skew_t3");
    push(base + 6, 32'h34000000, 32'hB4000000, 1'b1, 1'b1, 1'b0, "skew_t6");
    push(base + 7, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, "skew_t7");
    push(base + 9, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, "skew_t9");
    run_seq("skew", 99, 0, 8'h00, 99);

    // Write lockout during RUN, then replay shows the original value
    run_seq("lockout", 2, 0, 8'hFF, 99);
    push(cyc + 2, 32'h00000001, 32'h00000081, 1'b1, 1'b1, 1'b0, "replay_t0_orig");
    run_seq("replay", 99, 0, 8'h00, 99);

    // start while busy and start during DONE are both ignored
    run_seq("start_busy", 99, 0, 8'h00, 4);
    run_seq("start_done", 99, 0, 8'h00, 3*N-2);

    // Write in DONE is accepted; write together with start is used at t=0
    run_seq("wr_in_done", 3*N-2, 5, 8'h77, 99);
    push(cyc + 2, 32'h00000055, 32'h00000081, 1'b1, 1'b1, 1'b0, "wr_start_t0");
    run_seq("wr_with_start", -1, 0, 8'h55, 99);

    // Identity A and B[k][c] = 4k+c
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r*N + c, (r == c) ? 8'h01 : 8'h00);
        wr(1'b1, r*N + c, 8'(r*N + c));
      end
    run_seq("identity", 99, 0, 8'h00, 99);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    wr_en = 0; start = 1;
    base = cyc + 1;
    for (int t = 0; t <= 5; t++) push(base + t, lane_a(t), lane_b(t), 1'b1, 1'b1, 1'b0, "pre_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 0;
    end
    @(negedge clk);
    sb.delete();
    rst_n = 0;
    #1;
    chk_zero_now("async_reset_drop");
    for (int i = 1; i <= 3; i++) push(cyc + i, '0, '0, 1'b0, 1'b0, 1'b0, "in_reset_no_done");
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
    push(cyc + 1, '0, '0, 1'b0, 1'b0, 1'b0, "after_reset_no_done");
    @(negedge clk);
    run_seq("cleared_bufs", 99, 0, 8'h00, 99);

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
